// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RESET,
    S_RUN,
    S_DONE
  } state_e;

  localparam int DEF_N_MEM      = 3;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_CNT_W      = 32;

  // Channel select width; a single target still gets a 1-bit select.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_ctrl_cnt.sv
// Loadable saturating counter with a terminal-compare flag.
// DOWN=0 counts up and sticks at all-ones; DOWN=1 counts down and sticks at zero.
module run_ctrl_cnt #(
  parameter int W    = 8,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         step_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat;

  assign sat    = DOWN ? (cnt_q == '0) : (cnt_q == '1);
  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == term_i);

  // Load has priority over stepping; a saturated counter ignores steps.
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)
      cnt_d = ld_val_i;
    else if (step_i && !sat)
      cnt_d = DOWN ? (cnt_q - W'(1)) : (cnt_q + W'(1));
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: preload core memories, hold core in reset, run until halt
// or cycle limit, then freeze the core and report.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int N_MEM      = DEF_N_MEM,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  // Derived select width; leave at its default.
  parameter int CH_W       = chan_w(N_MEM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_req,
  input  logic              clear,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [CH_W-1:0]   ld_chan,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic [N_MEM-1:0]  mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              halt_in,
  output logic              core_rst_n,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              ld_err,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  state_e             state_q, state_d;
  logic [N_MEM-1:0]   we_d, we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   max_q;
  logic               timeout_q, ld_err_q;
  logic               xfer, chan_ok;
  logic               rst_ld, rst_step, rst_term;
  logic               run_ld, run_step, run_term;
  logic               max_ld, flags_clr, to_set;
  logic [RC_W-1:0]    unused_rst_cnt;
  logic [CNT_W-1:0]   run_cnt;

  assign xfer    = ld_valid && (state_q == S_LOAD);
  assign chan_ok = (int'(ld_chan) < N_MEM);

  // One-hot write strobe for the addressed target; bad channels write nothing.
  for (genvar g = 0; g < N_MEM; g++) begin : g_we
    assign we_d[g] = xfer && chan_ok && (int'(ld_chan) == g);
  end

  // RESET hold counter: counts RST_CYCLES-1 down to zero.
  run_ctrl_cnt #(.W(RC_W), .DOWN(1'b1)) u_rst_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (rst_ld),
    .ld_val_i (RC_W'(RST_CYCLES - 1)),
    .step_i   (rst_step),
    .term_i   ('0),
    .cnt_o    (unused_rst_cnt),
    .term_o   (rst_term)
  );

  // RUN cycle counter; terminal flag marks the last permitted cycle
  // (cnt+1 == max, only meaningful when max is non-zero).
  run_ctrl_cnt #(.W(CNT_W), .DOWN(1'b0)) u_run_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (run_ld),
    .ld_val_i ('0),
    .step_i   (run_step),
    .term_i   (max_q - CNT_W'(1)),
    .cnt_o    (run_cnt),
    .term_o   (run_term)
  );

  // Next-state and control strobes.
  always_comb begin
    state_d   = state_q;
    rst_ld    = 1'b0;
    rst_step  = 1'b0;
    run_ld    = 1'b0;
    run_step  = 1'b0;
    max_ld    = 1'b0;
    flags_clr = 1'b0;
    to_set    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        flags_clr = 1'b1;
        run_ld    = 1'b1;
        if (load_req) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_RESET;
          rst_ld  = 1'b1;
        end
      end
      S_LOAD: if (xfer && ld_last) begin
        state_d = S_RESET;
        rst_ld  = 1'b1;
      end
      S_RESET: begin
        if (rst_term) begin
          state_d = S_RUN;
          max_ld  = 1'b1;
        end else begin
          rst_step = 1'b1;
        end
      end
      S_RUN: begin
        run_step = 1'b1;
        // Halt takes priority over the limit.
        if (halt_in) begin
          state_d = S_DONE;
        end else if ((max_q != '0) && run_term) begin
          state_d = S_DONE;
          to_set  = 1'b1;
        end
      end
      S_DONE: if (clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Write port, status flags and the latched run limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      timeout_q <= 1'b0;
      ld_err_q  <= 1'b0;
      max_q     <= '0;
    end else begin
      we_q <= we_d;
      if (xfer && chan_ok) begin
        addr_q  <= ld_addr;
        wdata_q <= ld_data;
      end
      if (flags_clr) begin
        timeout_q <= 1'b0;
        ld_err_q  <= 1'b0;
      end else begin
        if (to_set)            timeout_q <= 1'b1;
        if (xfer && !chan_ok)  ld_err_q  <= 1'b1;
      end
      if (max_ld) max_q <= max_cycles;
    end
  end

  assign ld_ready   = (state_q == S_LOAD);
  assign core_rst_n = (state_q == S_RUN) || (state_q == S_DONE);
  assign core_en    = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign timeout    = timeout_q;
  assign ld_err     = ld_err_q;
  assign cycle_cnt  = run_cnt;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with hand-computed expectations.
module tb_run_ctrl;

  localparam int N_MEM = 3, ADDR_W = 10, DATA_W = 32, RST_CYCLES = 2, CNT_W = 32, CH_W = 2;

  logic              clk = 1'b0;
  logic              rst_n, start, load_req, clear, ld_valid, ld_last, halt_in;
  logic [CNT_W-1:0]  max_cycles;
  logic [CH_W-1:0]   ld_chan;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready, core_rst_n, core_en, busy, done, timeout, ld_err;
  logic [N_MEM-1:0]  mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [CNT_W-1:0]  cycle_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  run_ctrl #(
    .N_MEM(N_MEM), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_req(load_req), .clear(clear),
    .max_cycles(max_cycles), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_chan(ld_chan), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .halt_in(halt_in), .core_rst_n(core_rst_n), .core_en(core_en),
    .busy(busy), .done(done), .timeout(timeout), .ld_err(ld_err),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {core_rst_n, core_en, ld_ready, busy, done, timeout, ld_err} and the write port.
  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"}, 64'({core_rst_n, core_en, ld_ready, busy, done, timeout, ld_err}), 0);
    check({tag, "_we"},    64'(mem_we), 0);
    check({tag, "_addr"},  64'(mem_addr), 0);
    check({tag, "_wdata"}, 64'(mem_wdata), 0);
    check({tag, "_cnt"},   64'(cycle_cnt), 0);
  endtask

  task automatic beat(input int ch, input int a, input int d, input bit last);
    ld_valid = 1'b1;
    ld_chan  = CH_W'(ch);
    ld_addr  = ADDR_W'(a);
    ld_data  = DATA_W'(d);
    ld_last  = last;
  endtask

  int ch_t[5]   = '{0, 0, 0, 0, 1};
  int ad_t[5]   = '{0, 1, 2, 3, 'h10};
  int dt_t[5]   = '{'h20080001, 'h20080002, 'h20080003, 'h20080004, 'h0BADF00D};
  int we_t[5]   = '{1, 1, 1, 1, 2};

  initial begin
    int runs;
    rst_n = 1'b0; start = 1'b0; load_req = 1'b0; clear = 1'b0; halt_in = 1'b0;
    ld_valid = 1'b0; ld_last = 1'b0; ld_chan = '0; ld_addr = '0; ld_data = '0;
    max_cycles = '0;
    tick(); tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // --- load 4 inst beats + 1 data beat, then RESET/RUN, halt on RUN cycle 3
    start = 1'b1; load_req = 1'b1;
    tick();
    start = 1'b0;
    check("load_ready", 64'({ld_ready, busy, core_rst_n}), 'b110);
    for (int i = 0; i < 5; i++) begin
      beat(ch_t[i], ad_t[i], dt_t[i], i == 4);
      tick();
      check($sformatf("ld%0d_we", i),    64'(mem_we), 64'(we_t[i]));
      check($sformatf("ld%0d_addr", i),  64'(mem_addr), 64'(ad_t[i]));
      check($sformatf("ld%0d_wdata", i), 64'(mem_wdata), 64'(dt_t[i]));
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("ld_to_reset", 64'({ld_ready, busy, core_rst_n}), 'b010);
    tick();
    check("ld_we_drop", 64'(mem_we), 0);
    check("rst1_core_rst", 64'(core_rst_n), 0);
    tick();
    check("run1_core", 64'({core_rst_n, core_en}), 'b11);
    tick(); tick();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    check("h3_done", 64'({done, timeout, core_en, core_rst_n}), 'b1001);
    check("h3_cnt", 64'(cycle_cnt), 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_ign", 64'({done, busy}), 'b10);
    check("done_cnt_hold", 64'(cycle_cnt), 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_idle", 64'({done, busy, core_rst_n, core_en}), 0);

    // --- no load, unlimited, halt 10 cycles after release
    start = 1'b1; load_req = 1'b0; max_cycles = '0;
    tick();
    start = 1'b0;
    check("r1_state", 64'({core_rst_n, busy, ld_ready}), 'b010);
    check("r1_cnt_clr", 64'(cycle_cnt), 0);
    tick();
    check("r2_core_rst", 64'(core_rst_n), 0);
    tick();
    check("rel_core", 64'({core_rst_n, core_en}), 'b11);
    for (int i = 1; i <= 10; i++) begin
      clear = (i == 5);
      tick();
    end
    clear = 1'b0;
    check("run_clear_ign", 64'({core_en, done}), 'b10);
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    check("h11_flags", 64'({done, timeout, core_en, core_rst_n}), 'b1001);
    check("h11_cnt", 64'(cycle_cnt), 11);
    clear = 1'b1; tick(); clear = 1'b0;

    // --- limit 200, never halts
    max_cycles = 200;
    start = 1'b1;
    tick();
    start = 1'b0;
    runs = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      if (core_en) runs++;
      tick();
    end
    check("lim_done", 64'(done), 1);
    check("lim_runs", 64'(runs), 200);
    check("lim_flags", 64'({timeout, core_en}), 'b10);
    check("lim_cnt", 64'(cycle_cnt), 200);
    clear = 1'b1; tick(); clear = 1'b0;

    // --- limit 5 with halt on RUN cycle 5; limit latched on RUN entry
    max_cycles = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    max_cycles = 1000;
    tick(); tick(); tick(); tick();
    check("h5_running", 64'(core_en), 1);
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    check("h5_flags", 64'({done, timeout}), 'b10);
    check("h5_cnt", 64'(cycle_cnt), 5);
    clear = 1'b1; tick(); clear = 1'b0;

    // --- bad channel, sticky ld_err, then limit 1
    max_cycles = 1;
    start = 1'b1; load_req = 1'b1;
    tick();
    start = 1'b0;
    beat(3, 7, 'h55, 1'b0);
    tick();
    check("bad_we", 64'(mem_we), 0);
    check("bad_err", 64'(ld_err), 1);
    beat(2, 8, 'h66, 1'b1);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("gpr_we", 64'(mem_we), 'b100);
    check("gpr_addr", 64'(mem_addr), 8);
    check("err_sticky", 64'(ld_err), 1);
    tick(); tick(); tick();
    check("m1_flags", 64'({done, timeout, ld_err}), 'b111);
    check("m1_cnt", 64'(cycle_cnt), 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("idle_err_held", 64'(ld_err), 1);
    start = 1'b1; load_req = 1'b0;
    tick();
    start = 1'b0;
    check("start_clr", 64'({ld_err, timeout}), 0);
    check("start_cnt_clr", 64'(cycle_cnt), 0);

    // --- reset, stray beat in IDLE, then reset mid-LOAD with a beat in flight
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    beat(0, 9, 'h99, 1'b0);
    tick();
    ld_valid = 1'b0;
    check("idle_beat_ign", 64'({mem_we, mem_addr}), 0);
    start = 1'b1; load_req = 1'b1;
    tick();
    start = 1'b0;
    beat(0, 5, 'h77, 1'b0);
    tick();
    check("inflight_we", 64'(mem_we), 'b001);
    beat(1, 6, 'h88, 1'b0);
    rst_n = 1'b0;
    tick();
    check_reset_vals("midload_rst");
    rst_n = 1'b1; ld_valid = 1'b0;
    tick();
    check("post_rst_idle", 64'({busy, ld_ready, mem_we}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
